error_delimiter_ctrl: RTL and testbench
=======================================

// Module: error_delimiter_ctrl
// PURPOSE
//  Parametrised error/overload delimiter controller for the CAN error-frame path. Entered when the
//  error or overload flag completes. Drives recessive while waiting for the bus to release, then
//  times DELIM_LEN recessive bits. Also reports each DOM_SEQ_LEN-bit run of post-flag dominant
//  bits to fault confinement, form errors inside the delimiter, and a stuck-dominant timeout.
// PARAMETERS
//  DELIM_LEN     8    total recessive delimiter bits, including the first detected one (2..15)
//  DOM_SEQ_LEN   8    consecutive dominant bits per dom_seq_pulse (fault-confinement +8 rule)
//  MAX_DOM_BITS  128  dominant bits tolerated in WAIT_RECESSIVE before stuck_dominant
//  CNT_W         $clog2(MAX_DOM_BITS+1)  derived width of the dominant counter; do not override
// PORTS
//  clock           in   1      system clock
//  reset_n         in   1      asynchronous active-low reset
//  enable          in   1      0 = synchronous clear to reset values
//  sample_point    in   1      one-cycle strobe at the bit sample point
//  flag_complete   in   1      error/overload flag finished; start of delimiter phase
//  is_overload     in   1      sampled with flag_complete; 1 = overload delimiter
//  bus_recessive   in   1      sampled bus level is recessive
//  delim_bit       out  1      transmit bit; always 1 (recessive)
//  bit_counter     out  4      recessive delimiter bits counted so far
//  delim_complete  out  1      1-cycle pulse when the delimiter finishes normally
//  overload_done   out  1      copy of the latched is_overload, valid with delim_complete
//  dom_seq_pulse   out  1      1-cycle pulse per DOM_SEQ_LEN consecutive dominant bits
//  form_error      out  1      1-cycle pulse: dominant bit sampled inside the delimiter
//  stuck_dominant  out  1      sticky; set on MAX_DOM_BITS, cleared on return to IDLE
//  busy            out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Reset (async, or enable=0 at a clock edge) sets:
//   state=IDLE, delim_bit=1, bit_counter=0, pulses=0, stuck_dominant=0, dom counters=0.
//  All outputs are registered. Pulses appear in the cycle after the triggering sample_point.
//  IDLE: on flag_complete, latch is_overload, clear counters, go to WAIT_RECESSIVE.
//  WAIT_RECESSIVE, on sample_point:
//   - recessive -> bit_counter=1, go to DELIM (1 bit already counted).
//   - dominant  -> dom_run++, dom_total++ (dom_total saturates).
//   - when dom_run reaches DOM_SEQ_LEN: pulse dom_seq_pulse, dom_run=0.
//   - when dom_total reaches MAX_DOM_BITS: set stuck_dominant, stay in state, keep counting runs.
//  DELIM, on sample_point:
//   - recessive -> bit_counter++.
//   - recessive with bit_counter==DELIM_LEN-1 -> pulse delim_complete, go to DONE.
//   - dominant  -> pulse form_error, go to IDLE. Caller restarts an error frame.
//  DONE: one cycle; bit_counter holds DELIM_LEN; go to IDLE.
//  IDLE clears bit_counter and stuck_dominant on its first cycle.
//  flag_complete outside IDLE is ignored.
//  flag_complete and sample_point in the same IDLE cycle: the sample is not evaluated.
//  With DELIM_LEN=8, delim_complete is ~7 bit times after the first recessive sample.
//  delim_complete and form_error are mutually exclusive.
//  dom_seq_pulse never fires outside WAIT_RECESSIVE.
//  bit_counter width is fixed at 4 bits; elaborate-time assertion 2 <= DELIM_LEN <= 15.
// STRUCTURE
//  Package can_err_pkg holds:
//   - delim_state_t enum {IDLE, WAIT_RECESSIVE, DELIM, DONE}
//   - default delimiter and fault-confinement constants (8, 8, 128)
//  Sub-module dom_run_counter holds dom_run, dom_total, dom_seq_pulse and the saturating stuck
//  flag, with a clear input; this FSM instantiates it once.
// TESTING
//  1 flag_complete; bus recessive from the next sample -> delim_complete 8th sample later,
//    bit_counter=8, then busy=0.
//  2 3 dominant samples, then 8 recessive -> no dom_seq_pulse; completes after 11 samples total.
//  3 17 dominant samples after the flag -> dom_seq_pulse exactly twice (8th, 16th), then completes
//    normally.
//  4 Dominant on the 4th delimiter sample -> form_error pulse, no delim_complete, state IDLE.
//  5 128 dominant samples -> stuck_dominant=1; a recessive sample then completes; sticky bit
//    clears in IDLE.
//  6 reset_n low, then enable low, each mid-DELIM -> all outputs at reset values;
//    DELIM_LEN=3 build completes after 3 samples.

Source files
------------

// File: rtl/can_err_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : can_err_pkg                                                    |
// | Purpose : Shared types and default constants for the CAN error-frame     |
// |           delimiter path (delimiter FSM state, fault-confinement limits).|
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package can_err_pkg;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    WAIT_RECESSIVE = 2'd1,
    DELIM          = 2'd2,
    DONE           = 2'd3
  } delim_state_t;

  // Default delimiter length and fault-confinement limits
  localparam int unsigned DEF_DELIM_LEN    = 8;
  localparam int unsigned DEF_DOM_SEQ_LEN  = 8;
  localparam int unsigned DEF_MAX_DOM_BITS = 128;

endpackage : can_err_pkg
`default_nettype wire

// File: rtl/error_delimiter_ctrl_dom_run_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dom_run_counter                                                |
// | Purpose : Counts dominant bits seen after an error/overload flag.        |
// |           Emits one pulse per DOM_SEQ_LEN consecutive dominant bits and  |
// |           raises a sticky flag once MAX_DOM_BITS dominant bits were seen.|
// | Ports   : clk, rst_n        clock / async active-low reset               |
// |           i_clear           synchronous clear of all counters and flags  |
// |           i_inc             one dominant bit sampled this cycle          |
// |           o_dom_seq_pulse   registered 1-cycle pulse per full run        |
// |           o_stuck           sticky, set when the total reaches the limit |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module dom_run_counter #(
  parameter int unsigned DOM_SEQ_LEN  = 8,
  parameter int unsigned MAX_DOM_BITS = 128,
  parameter int unsigned CNT_W        = $clog2(MAX_DOM_BITS + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_dom_seq_pulse,
  output logic o_stuck
);

  localparam int unsigned RUN_W = $clog2(DOM_SEQ_LEN + 1);

  logic [RUN_W-1:0] r_dom_run;
  logic [CNT_W-1:0] r_dom_total;
  logic             r_seq_pulse;
  logic             r_stuck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dom_run   <= '0;
      r_dom_total <= '0;
      r_seq_pulse <= 1'b0;
      r_stuck     <= 1'b0;
    end else if (i_clear) begin
      r_dom_run   <= '0;
      r_dom_total <= '0;
      r_seq_pulse <= 1'b0;
      r_stuck     <= 1'b0;
    end else begin
      r_seq_pulse <= 1'b0;
      if (i_inc) begin
        // Run counter wraps to zero on the bit that completes a run
        if (r_dom_run == RUN_W'(DOM_SEQ_LEN - 1)) begin
          r_dom_run   <= '0;
          r_seq_pulse <= 1'b1;
        end else begin
          r_dom_run <= r_dom_run + 1'b1;
        end
        // Total saturates so the stuck flag can never be lost to a wrap
        if (r_dom_total != CNT_W'(MAX_DOM_BITS)) begin
          r_dom_total <= r_dom_total + 1'b1;
        end
        if (r_dom_total >= CNT_W'(MAX_DOM_BITS - 1)) begin
          r_stuck <= 1'b1;
        end
      end
    end
  end

  assign o_dom_seq_pulse = r_seq_pulse;
  assign o_stuck         = r_stuck;

endmodule : dom_run_counter
`default_nettype wire

// File: rtl/error_delimiter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : error_delimiter_ctrl                                           |
// | Purpose : CAN error/overload delimiter controller. After the flag ends   |
// |           it transmits recessive, waits for the bus to release, times    |
// |           DELIM_LEN recessive bits and reports dominant runs, form       |
// |           errors and a stuck-dominant bus.                               |
// | Ports   : clk, rst_n          clock / async active-low reset             |
// |           i_enable            0 = synchronous clear                      |
// |           i_sample_point      1-cycle strobe at the bit sample point     |
// |           i_flag_complete     error/overload flag finished               |
// |           i_is_overload       sampled with i_flag_complete               |
// |           i_bus_recessive     sampled bus level is recessive             |
// |           o_delim_bit         transmit bit, always recessive             |
// |           o_bit_counter[3:0]  recessive delimiter bits counted           |
// |           o_delim_complete    pulse: delimiter finished normally         |
// |           o_overload_done     latched is_overload                        |
// |           o_dom_seq_pulse     pulse per DOM_SEQ_LEN dominant bits        |
// |           o_form_error        pulse: dominant bit inside the delimiter   |
// |           o_stuck_dominant    sticky stuck-dominant indication           |
// |           o_busy              controller not idle                        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module error_delimiter_ctrl
  import can_err_pkg::*;
#(
  parameter int unsigned DELIM_LEN    = DEF_DELIM_LEN,
  parameter int unsigned DOM_SEQ_LEN  = DEF_DOM_SEQ_LEN,
  parameter int unsigned MAX_DOM_BITS = DEF_MAX_DOM_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_enable,
  input  logic       i_sample_point,
  input  logic       i_flag_complete,
  input  logic       i_is_overload,
  input  logic       i_bus_recessive,
  output logic       o_delim_bit,
  output logic [3:0] o_bit_counter,
  output logic       o_delim_complete,
  output logic       o_overload_done,
  output logic       o_dom_seq_pulse,
  output logic       o_form_error,
  output logic       o_stuck_dominant,
  output logic       o_busy
);

  localparam int unsigned CNT_W = $clog2(MAX_DOM_BITS + 1);

  generate
    if ((DELIM_LEN < 2) || (DELIM_LEN > 15)) begin : g_bad_delim_len
      $error("error_delimiter_ctrl: DELIM_LEN must be in 2..15");
    end
  endgenerate

  delim_state_t r_state;
  delim_state_t w_state_nxt;
  logic [3:0]   r_bit_counter;
  logic [3:0]   w_bit_counter_nxt;
  logic         r_delim_complete;
  logic         w_delim_complete_nxt;
  logic         r_form_error;
  logic         w_form_error_nxt;
  logic         r_overload;
  logic         w_overload_nxt;
  logic         r_busy;
  logic         w_busy_nxt;
  logic         r_delim_bit;
  logic         w_dom_inc;
  logic         w_dom_clear;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_bit_counter    <= 4'd0;
      r_delim_complete <= 1'b0;
      r_form_error     <= 1'b0;
      r_overload       <= 1'b0;
      r_busy           <= 1'b0;
      r_delim_bit      <= 1'b1;
    end else begin
      r_state          <= w_state_nxt;
      r_bit_counter    <= w_bit_counter_nxt;
      r_delim_complete <= w_delim_complete_nxt;
      r_form_error     <= w_form_error_nxt;
      r_overload       <= w_overload_nxt;
      r_busy           <= w_busy_nxt;
      r_delim_bit      <= 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt          = r_state;
    w_bit_counter_nxt    = r_bit_counter;
    w_delim_complete_nxt = 1'b0;
    w_form_error_nxt     = 1'b0;
    w_overload_nxt       = r_overload;

    if (!i_enable) begin
      w_state_nxt       = IDLE;
      w_bit_counter_nxt = 4'd0;
      w_overload_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // A sample strobe coinciding with the flag is deliberately ignored
          w_bit_counter_nxt = 4'd0;
          if (i_flag_complete) begin
            w_overload_nxt = i_is_overload;
            w_state_nxt    = WAIT_RECESSIVE;
          end
        end
        WAIT_RECESSIVE: begin
          // The first recessive bit already counts toward the delimiter
          if (i_sample_point && i_bus_recessive) begin
            w_bit_counter_nxt = 4'd1;
            w_state_nxt       = DELIM;
          end
        end
        DELIM: begin
          if (i_sample_point) begin
            if (i_bus_recessive) begin
              w_bit_counter_nxt = r_bit_counter + 4'd1;
              if (r_bit_counter == 4'(DELIM_LEN - 1)) begin
                w_delim_complete_nxt = 1'b1;
                w_state_nxt          = DONE;
              end
            end else begin
              w_form_error_nxt  = 1'b1;
              w_bit_counter_nxt = 4'd0;
              w_state_nxt       = IDLE;
            end
          end
        end
        DONE: begin
          w_bit_counter_nxt = 4'd0;
          w_state_nxt       = IDLE;
        end
        default: begin
          w_bit_counter_nxt = 4'd0;
          w_state_nxt       = IDLE;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // Dominant counting only runs while waiting for the bus to release; it is
  // held clear in IDLE and on the way into IDLE so the sticky flag drops there.
  assign w_dom_inc   = i_enable && (r_state == WAIT_RECESSIVE) &&
                       i_sample_point && !i_bus_recessive;
  assign w_dom_clear = !i_enable || (r_state == IDLE) || (w_state_nxt == IDLE);

  dom_run_counter #(
    .DOM_SEQ_LEN  (DOM_SEQ_LEN),
    .MAX_DOM_BITS (MAX_DOM_BITS),
    .CNT_W        (CNT_W)
  ) u_dom_run_counter (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (w_dom_clear),
    .i_inc           (w_dom_inc),
    .o_dom_seq_pulse (o_dom_seq_pulse),
    .o_stuck         (o_stuck_dominant)
  );

  assign o_delim_bit      = r_delim_bit;
  assign o_bit_counter    = r_bit_counter;
  assign o_delim_complete = r_delim_complete;
  assign o_overload_done  = r_overload;
  assign o_form_error     = r_form_error;
  assign o_busy           = r_busy;

endmodule : error_delimiter_ctrl
`default_nettype wire

// File: tb/tb_error_delimiter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_error_delimiter_ctrl                                        |
// | Purpose : Self-checking bench for error_delimiter_ctrl. Each transaction |
// |           is a flag followed by a bit sequence described by the number   |
// |           of leading dominant bits and an optional dominant position     |
// |           inside the delimiter; expectations are derived from those.     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_error_delimiter_ctrl;

  localparam int DL = 8;
  localparam int DS = 8;
  localparam int MX = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sample, flag, ovl_in, bus;
  logic       delim_bit, complete, ovl_done, seq_pulse, form_err, stuck, busy;
  logic [3:0] bit_cnt;

  logic       s2, f2, b2;
  logic       delim_bit2, complete2, ovl_done2, seq_pulse2, form_err2, stuck2, busy2;
  logic [3:0] bit_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  error_delimiter_ctrl #(.DELIM_LEN(DL), .DOM_SEQ_LEN(DS), .MAX_DOM_BITS(MX)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_sample_point(sample),
    .i_flag_complete(flag), .i_is_overload(ovl_in), .i_bus_recessive(bus),
    .o_delim_bit(delim_bit), .o_bit_counter(bit_cnt), .o_delim_complete(complete),
    .o_overload_done(ovl_done), .o_dom_seq_pulse(seq_pulse), .o_form_error(form_err),
    .o_stuck_dominant(stuck), .o_busy(busy)
  );

  error_delimiter_ctrl #(.DELIM_LEN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_sample_point(s2),
    .i_flag_complete(f2), .i_is_overload(1'b1), .i_bus_recessive(b2),
    .o_delim_bit(delim_bit2), .o_bit_counter(bit_cnt2), .o_delim_complete(complete2),
    .o_overload_done(ovl_done2), .o_dom_seq_pulse(seq_pulse2), .o_form_error(form_err2),
    .o_stuck_dominant(stuck2), .o_busy(busy2)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle();
    chk_eq("idle_busy", busy, 0);
    chk_eq("idle_cnt", bit_cnt, 0);
    chk_eq("idle_stuck", stuck, 0);
    chk_eq("idle_done", complete, 0);
    chk_eq("idle_form", form_err, 0);
    chk_eq("idle_seq", seq_pulse, 0);
    chk_eq("idle_txbit", delim_bit, 1);
  endtask

  // Non-sample cycles between bit times; bus noise and stray flags must be ignored
  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      sample = 1'b0;
      bus    = 1'($urandom_range(0, 1));
      flag   = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      flag = 1'b0;
      chk_eq("gap_seq", seq_pulse, 0);
      chk_eq("gap_form", form_err, 0);
      chk_eq("gap_done", complete, 0);
      chk_eq("gap_txbit", delim_bit, 1);
    end
  endtask

  task automatic start_flag(input logic ovl);
    @(negedge clk);
    flag   = 1'b1;
    ovl_in = ovl;
    sample = 1'($urandom_range(0, 1));
    bus    = 1'($urandom_range(0, 1));
    @(negedge clk);
    flag   = 1'b0;
    sample = 1'b0;
    chk_eq("flag_busy", busy, 1);
    chk_eq("flag_cnt", bit_cnt, 0);
    chk_eq("flag_stuck", stuck, 0);
  endtask

  // d leading dominant bits, then the delimiter; inj in 1..DL-1 places a
  // dominant bit at that delimiter position, 0 means a clean delimiter.
  task automatic run_txn(input int d, input int inj);
    logic ovl;
    int   n;
    logic rec, e_form, e_done;
    int   e_cnt;
    ovl = 1'($urandom_range(0, 1));
    start_flag(ovl);
    n = (inj == 0) ? d + DL : d + inj + 1;
    for (int i = 0; i < n; i++) begin
      gap();
      rec    = (i >= d) && !((inj != 0) && (i == d + inj));
      e_form = (inj != 0) && (i == d + inj);
      e_done = (inj == 0) && (i == d + DL - 1);
      e_cnt  = (i < d || e_form) ? 0 : i - d + 1;
      sample = 1'b1;
      bus    = rec;
      @(negedge clk);
      sample = 1'b0;
      chk_eq("seq_pulse", seq_pulse, ((i < d) && ((i + 1) % DS == 0)) ? 1 : 0);
      chk_eq("form_error", form_err, e_form);
      chk_eq("delim_complete", complete, e_done);
      chk_eq("bit_counter", bit_cnt, e_cnt);
      chk_eq("busy", busy, !e_form);
      chk_eq("stuck", stuck, (!e_form && d >= MX && i >= MX - 1) ? 1 : 0);
      if (e_done) chk_eq("overload_done", ovl_done, ovl);
    end
    @(negedge clk);
    chk_idle();
  endtask

  // Bring the main instance into DELIM with k counted bits, without checking
  task automatic enter_delim(input int k);
    start_flag(1'b1);
    for (int i = 0; i < k; i++) begin
      sample = 1'b1;
      bus    = 1'b1;
      @(negedge clk);
      sample = 1'b0;
      @(negedge clk);
    end
    chk_eq("pre_reset_cnt", bit_cnt, k);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1;
    sample = 1'b0; flag = 1'b0; ovl_in = 1'b0; bus = 1'b1;
    s2 = 1'b0; f2 = 1'b0; b2 = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle();
    chk_eq("rst_ovl", ovl_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle();

    // Directed cases
    run_txn(0, 0);
    run_txn(3, 0);
    run_txn(17, 0);
    run_txn(0, 3);
    run_txn(MX, 0);
    run_txn(MX + 2, 5);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      int d, inj;
      d   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MX - 2, MX + 5))
                                        : int'($urandom_range(0, 20));
      inj = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, DL - 1));
      run_txn(d, inj);
    end

    // Asynchronous reset in the middle of the delimiter
    enter_delim(2);
    #2 rst_n = 1'b0;
    #1;
    chk_idle();
    chk_eq("arst_ovl", ovl_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle();

    // Synchronous clear through enable in the middle of the delimiter
    enter_delim(3);
    enable = 1'b0;
    @(negedge clk);
    chk_idle();
    chk_eq("en_ovl", ovl_done, 0);
    enable = 1'b1;
    run_txn(1, 0);

    // Short delimiter build: completes on the third recessive sample
    @(negedge clk);
    f2 = 1'b1;
    @(negedge clk);
    f2 = 1'b0;
    chk_eq("d3_busy", busy2, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s2 = 1'b1;
      b2 = 1'b1;
      @(negedge clk);
      s2 = 1'b0;
      chk_eq("d3_cnt", bit_cnt2, i + 1);
      chk_eq("d3_done", complete2, (i == 2) ? 1 : 0);
    end
    chk_eq("d3_ovl", ovl_done2, 1);
    @(negedge clk);
    chk_eq("d3_idle", busy2, 0);
    chk_eq("d3_cnt0", bit_cnt2, 0);
    chk_eq("d3_quiet", {seq_pulse2, form_err2, stuck2}, 0);
    chk_eq("d3_txbit", delim_bit2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_error_delimiter_ctrl
`default_nettype wire
